// File: rtl/led_status_arbiter.sv
// led_status_arbiter
//   Shares one front-panel status LED between NUM_REQ requesters. Ownership is
//   granted by fixed priority, where index 0 is the highest. Once an owner holds
//   the LED for MIN_HOLD cycles, a higher-priority requester may preempt it. The
//   LED is driven in the owner's selected mode: off, solid, blink or glow.
//   Glow is a triangle-ramped 4-bit level fed into a first-order sigma-delta PWM.
//
// Ports
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   req      in   [NUM_REQ-1:0]   per-requester level request
//   mode     in   [2*NUM_REQ-1:0] per-requester mode (0 off, 1 on, 2 blink, 3 glow)
//   grant    out  [NUM_REQ-1:0]   one-hot current owner, zero when idle
//   busy     out  high while any grant is active
//   led      out  registered LED drive
module led_status_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned BITPOS    = 23,
  parameter int unsigned BLINK_BIT = 22,
  parameter int unsigned MIN_HOLD  = 1048576
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [2*NUM_REQ-1:0]   mode,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   led
);

  localparam int unsigned HoldW = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;
  localparam logic [HoldW-1:0]   HoldMax = HoldW'(MIN_HOLD);
  localparam logic [HoldW-1:0]   HoldOne = HoldW'(1);
  localparam logic [BITPOS:0]    CntOne  = (BITPOS + 1)'(1);
  localparam logic [NUM_REQ-1:0] ReqOne  = NUM_REQ'(1);

  localparam logic [1:0] ModeOff   = 2'd0;
  localparam logic [1:0] ModeOn    = 2'd1;
  localparam logic [1:0] ModeBlink = 2'd2;

  typedef enum logic {StIdle, StOwn} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic               busy_q, busy_d;
  logic               led_q, led_d;
  logic [BITPOS:0]    cnt_q, cnt_d;
  logic [4:0]         pwm_q, pwm_d;

  logic [NUM_REQ-1:0] lowest_oh;
  logic [NUM_REQ-1:0] higher_req;
  logic               any_req;
  logic               owner_req;
  logic               hold_done;
  logic [3:0]         lvl_field;
  logic [3:0]         lvl;
  logic [1:0]         owner_mode;

  // Isolate the lowest set bit: x & -x.
  assign lowest_oh  = req & (~req + ReqOne);
  // For a one-hot owner, grant_q - 1 masks every index below it, i.e. higher priority.
  assign higher_req = req & (grant_q - ReqOne);
  assign any_req    = |req;
  assign owner_req  = |(req & grant_q);
  assign hold_done  = (hold_q == HoldMax);

  // The glow ramps up while cnt[BITPOS] is set and ramps down while it is clear.
  assign lvl_field = cnt_q[BITPOS-1 -: 4];
  assign lvl       = cnt_q[BITPOS] ? lvl_field : ~lvl_field;
  assign cnt_d     = cnt_q + CntOne;
  assign pwm_d     = {1'b0, pwm_q[3:0]} + {1'b0, lvl};

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      led_q   <= 1'b0;
      cnt_q   <= '0;
      pwm_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      led_q   <= led_d;
      cnt_q   <= cnt_d;
      pwm_q   <= pwm_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle: begin
        grant_d = '0;
        hold_d  = '0;
        if (any_req) begin
          grant_d = lowest_oh;
          state_d = StOwn;
        end
      end
      StOwn: begin
        if (!owner_req) begin
          // Release never waits for the hold; hand over or fall idle.
          hold_d = '0;
          if (any_req) begin
            grant_d = lowest_oh;
          end else begin
            grant_d = '0;
            state_d = StIdle;
          end
        end else if (hold_done && (|higher_req)) begin
          grant_d = lowest_oh;
          hold_d  = '0;
        end else if (!hold_done) begin
          hold_d = hold_q + HoldOne;
        end
      end
      default: begin
        grant_d = '0;
        hold_d  = '0;
        state_d = StIdle;
      end
    endcase
    busy_d = |grant_d;
  end

  // Output logic: led follows the current owner's live mode, or is off when idle.
  always_comb begin
    owner_mode = 2'b00;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      owner_mode = owner_mode | (mode[2*i +: 2] & {2{grant_q[i]}});
    end
    case (owner_mode)
      ModeOff:   led_d = 1'b0;
      ModeOn:    led_d = 1'b1;
      ModeBlink: led_d = cnt_q[BLINK_BIT];
      default:   led_d = pwm_q[4];
    endcase
  end

  assign grant = grant_q;
  assign busy  = busy_q;
  assign led   = led_q;

endmodule

// File: tb/tb_led_status_arbiter.sv
module tb_led_status_arbiter;

  localparam int NR = 4;
  localparam int BP = 5;
  localparam int BB = 2;
  localparam int MH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req = '0;
  logic [7:0]  mode = '0;
  logic [3:0]  grant;
  logic        busy;
  logic        led;

  led_status_arbiter #(
    .NUM_REQ  (NR),
    .BITPOS   (BP),
    .BLINK_BIT(BB),
    .MIN_HOLD (MH)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .req    (req),
    .mode   (mode),
    .grant  (grant),
    .busy   (busy),
    .led    (led)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] grant;
    logic       busy;
    logic       led;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: owner index (-1 idle), cycles held, free-running phase
  // counter, and the sigma-delta accumulator with its last carry.
  int m_owner = -1;
  int m_hold  = 0;
  int m_cnt   = 0;
  int m_acc   = 0;
  int m_carry = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_hold  = 0;
    m_cnt   = 0;
    m_acc   = 0;
    m_carry = 0;
  endtask

  // Predict the outputs after the coming clock edge from the inputs now applied.
  task automatic model_step();
    int   lowest;
    int   md;
    int   lvl;
    int   sum;
    int   nl;
    exp_t e;
    lowest = -1;
    for (int i = NR - 1; i >= 0; i--) if (req[i]) lowest = i;

    nl = 0;
    if (m_owner >= 0) begin
      md = int'((mode >> (2 * m_owner)) & 8'd3);
      case (md)
        0: nl = 0;
        1: nl = 1;
        2: nl = (m_cnt >> BB) & 1;
        default: nl = m_carry;
      endcase
    end

    // Triangle level: rising in the upper half of the period, falling in the lower.
    lvl = (m_cnt >> (BP - 4)) & 15;
    if (m_cnt < (1 << BP)) lvl = 15 - lvl;
    sum     = m_acc + lvl;
    m_carry = (sum >= 16) ? 1 : 0;
    m_acc   = sum % 16;
    m_cnt   = (m_cnt + 1) % (1 << (BP + 1));

    if (m_owner < 0) begin
      if (lowest >= 0) begin
        m_owner = lowest;
        m_hold  = 0;
      end
    end else if (!req[m_owner]) begin
      m_owner = lowest;
      m_hold  = 0;
    end else if (m_hold == MH && lowest < m_owner) begin
      m_owner = lowest;
      m_hold  = 0;
    end else if (m_hold < MH) begin
      m_hold++;
    end

    e.grant = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    e.busy  = (m_owner >= 0);
    e.led   = nl[0];
    q.push_back(e);
  endtask

  task automatic drive(input logic [3:0] r, input logic [7:0] m);
    @(negedge clk);
    req  = r;
    mode = m;
    model_step();
  endtask

  // Mid-cycle asynchronous reset: outputs must clear with no clock edge.
  task automatic async_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_grant", int'(grant), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_led", int'(led), 0);
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    model_step();
  endtask

  // Monitor: one expected entry per active clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("grant", int'(grant), int'(e.grant));
        check("busy", int'(busy), int'(e.busy));
        check("led", int'(led), int'(e.led));
      end
    end
  end

  initial begin
    logic [3:0] r;
    logic [7:0] m;
    #1;
    check("reset_grant", int'(grant), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_led", int'(led), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    model_step();

    // Idle with no requests.
    repeat (100) drive(4'b0000, 8'h00);

    // Requester 1 owns (index 3 also asserted), first solid then blinking.
    repeat (10) drive(4'b1010, 8'h04);
    repeat (20) drive(4'b1010, 8'h08);

    // Requester 2 owns in glow; requester 0 rises one cycle later and must wait.
    drive(4'b0100, 8'h30);
    repeat (12) drive(4'b0101, 8'h30);

    // Owner 0 drops while 3 is waiting: immediate handover, then idle.
    repeat (2) drive(4'b1001, 8'hC1);
    repeat (3) drive(4'b1000, 8'hC1);
    repeat (3) drive(4'b0000, 8'hC1);

    // Continuous glow across more than two full periods.
    repeat (160) drive(4'b0001, 8'h03);

    // Reset mid-ownership with the request held.
    repeat (5) drive(4'b0100, 8'h10);
    async_reset();
    repeat (5) drive(4'b0100, 8'h10);

    // Randomised slow-toggling requests and occasional mode changes.
    for (int c = 0; c < 3000; c++) begin
      r = req;
      m = mode;
      for (int b = 0; b < NR; b++) if ($urandom_range(0, 15) == 0) r[b] = ~r[b];
      if ($urandom_range(0, 7) == 0) m = 8'($urandom);
      drive(r, m);
      if (c == 1500) begin
        repeat (4) drive(4'b0010, 8'h0C);
        async_reset();
      end
    end

    @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
